// File: rtl/spk_schmitt_trigger.sv
// -----------------------------------------------------------------------------
// spk_schmitt_trigger
//
// Purpose:
//   Per-neuron spike generator with hysteresis. The neuron's signed membrane
//   potential is compared against a programmable high (fire) threshold and a
//   low (re-arm) threshold. The comparison is gated by the neuron's stored
//   spikability bit. The spike and the next spikability are produced
//   combinationally, so the block can be replicated inside the lane arrays of
//   the spike processor. The block also holds the two threshold registers, a
//   sticky configuration error flag and a saturating spike counter.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   potential    in   signed membrane potential (WIDTH bits)
//   spkblty_in   in   stored spikability: 1 = armed, 0 = refractory
//   spk          out  spike, combinational
//   spkblty_out  out  next spikability, combinational; the caller writes it back
//   count_en     in   marks this cycle's evaluation as one to be counted
//   cfg_we       in   threshold write strobe
//   cfg_th_high  in   new high threshold (signed)
//   cfg_th_low   in   new low threshold (signed)
//   cfg_err      out  sticky flag: a threshold write was rejected
//   cnt_clr      in   clear the spike counter
//   spk_count    out  saturating count of counted spikes
//   th_high      out  current high threshold
//   th_low       out  current low threshold
// -----------------------------------------------------------------------------
module spk_schmitt_trigger #(
    parameter int                      WIDTH       = 8,
    parameter logic signed [WIDTH-1:0] TH_HIGH_RST = 8'sd64,
    parameter logic signed [WIDTH-1:0] TH_LOW_RST  = 8'sd0,
    parameter int                      CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     potential,
    input  logic                 spkblty_in,
    output logic                 spk,
    output logic                 spkblty_out,
    input  logic                 count_en,
    input  logic                 cfg_we,
    input  logic [WIDTH-1:0]     cfg_th_high,
    input  logic [WIDTH-1:0]     cfg_th_low,
    output logic                 cfg_err,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] spk_count,
    output logic [WIDTH-1:0]     th_high,
    output logic [WIDTH-1:0]     th_low
);

    logic [WIDTH-1:0]     r_thHigh;
    logic [WIDTH-1:0]     r_thLow;
    logic                 r_cfgErr;
    logic [CNT_WIDTH-1:0] r_spkCount;

    logic w_geHigh;
    logic w_ltLow;
    logic w_fire;
    logic w_rearm;
    logic w_cfgValid;
    logic w_cntFull;

    // Signed comparisons against the live threshold registers. Equality at the
    // high threshold fires; equality at the low threshold does not re-arm.
    assign w_geHigh = $signed(potential) >= $signed(r_thHigh);
    assign w_ltLow  = $signed(potential) <  $signed(r_thLow);

    // An armed neuron fires at or above the high threshold and goes refractory.
    // A refractory neuron only re-arms once it falls strictly below the low
    // threshold. A refractory neuron can never fire.
    assign w_fire      = spkblty_in & w_geHigh;
    assign w_rearm     = ~spkblty_in & w_ltLow;
    assign spk         = w_fire;
    assign spkblty_out = (spkblty_in & ~w_fire) | w_rearm;

    // A threshold pair is only accepted when low is strictly below high, so the
    // hysteresis band can never collapse or invert.
    assign w_cfgValid = $signed(cfg_th_low) < $signed(cfg_th_high);

    assign w_cntFull = &r_spkCount;

    // Threshold registers and sticky error flag. A rejected write leaves both
    // thresholds untouched and latches the error until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_thHigh <= TH_HIGH_RST;
            r_thLow  <= TH_LOW_RST;
            r_cfgErr <= 1'b0;
        end else if (cfg_we) begin
            if (w_cfgValid) begin
                r_thHigh <= cfg_th_high;
                r_thLow  <= cfg_th_low;
            end else begin
                r_cfgErr <= 1'b1;
            end
        end
    end

    // Spike counter. Clear beats a simultaneous spike; once all ones the
    // counter holds rather than wrapping back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spkCount <= '0;
        end else if (cnt_clr) begin
            r_spkCount <= '0;
        end else if (count_en && w_fire && !w_cntFull) begin
            r_spkCount <= r_spkCount + 1'b1;
        end
    end

    assign th_high   = r_thHigh;
    assign th_low    = r_thLow;
    assign cfg_err   = r_cfgErr;
    assign spk_count = r_spkCount;

endmodule

// File: tb/tb_spk_schmitt_trigger.sv
// -----------------------------------------------------------------------------
// tb_spk_schmitt_trigger
//
// Self-checking bench for spk_schmitt_trigger. A behavioural model in plain
// integer arithmetic tracks thresholds, the error flag and the spike count;
// every cycle the DUT outputs are compared against it. Directed sequences
// cover the interesting corners, then randomized traffic runs on top.
// -----------------------------------------------------------------------------
module tb_spk_schmitt_trigger;

    logic        clk;
    logic        reset;
    logic [7:0]  potential;
    logic        spkblty_in;
    logic        spk;
    logic        spkblty_out;
    logic        count_en;
    logic        cfg_we;
    logic [7:0]  cfg_th_high;
    logic [7:0]  cfg_th_low;
    logic        cfg_err;
    logic        cnt_clr;
    logic [15:0] spk_count;
    logic [7:0]  th_high;
    logic [7:0]  th_low;

    int testsRun;
    int testsFailed;

    // Reference model state
    int mHigh;
    int mLow;
    int mCount;
    int mErr;

    // Last observed DUT core outputs, used for spikability feedback
    int lastSpk;
    int lastSbOut;

    spk_schmitt_trigger dut (
        .clk         (clk),
        .reset       (reset),
        .potential   (potential),
        .spkblty_in  (spkblty_in),
        .spk         (spk),
        .spkblty_out (spkblty_out),
        .count_en    (count_en),
        .cfg_we      (cfg_we),
        .cfg_th_high (cfg_th_high),
        .cfg_th_low  (cfg_th_low),
        .cfg_err     (cfg_err),
        .cnt_clr     (cnt_clr),
        .spk_count   (spk_count),
        .th_high     (th_high),
        .th_low      (th_low)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, checks every output
    // against the model, then advances the model at the rising edge.
    task automatic applyStimulus(input bit rst, input int pot, input bit sb, input bit en,
                                 input bit we, input int hi, input int lo, input bit clr);
        bit fire;
        bit rearm;
        @(negedge clk);
        reset       = rst;
        potential   = 8'(pot);
        spkblty_in  = sb;
        count_en    = en;
        cfg_we      = we;
        cfg_th_high = 8'(hi);
        cfg_th_low  = 8'(lo);
        cnt_clr     = clr;
        #1;
        fire  = sb && (pot >= mHigh);
        rearm = !sb && (pot < mLow);
        lastSpk   = int'(spk);
        lastSbOut = int'(spkblty_out);
        checkOutput("spk", lastSpk, int'(fire));
        checkOutput("spkblty_out", lastSbOut, int'((sb && !fire) || rearm));
        checkOutput("spk_count", int'(spk_count), mCount);
        checkOutput("th_high", int'($signed(th_high)), mHigh);
        checkOutput("th_low", int'($signed(th_low)), mLow);
        checkOutput("cfg_err", int'(cfg_err), mErr);
        @(posedge clk);
        if (rst) begin
            mHigh  = 64;
            mLow   = 0;
            mErr   = 0;
            mCount = 0;
        end else begin
            if (we) begin
                if (lo < hi) begin
                    mHigh = hi;
                    mLow  = lo;
                end else begin
                    mErr = 1;
                end
            end
            if (clr) mCount = 0;
            else if (en && fire && mCount < 65535) mCount++;
        end
    endtask

    initial begin
        int fbSpkExp[5];
        int fbSbExp[5];
        int fbPot[5];
        bit sb;
        testsRun    = 0;
        testsFailed = 0;
        mHigh = 64; mLow = 0; mCount = 0; mErr = 0;
        reset = 1'b1; potential = '0; spkblty_in = 1'b0; count_en = 1'b0;
        cfg_we = 1'b0; cfg_th_high = '0; cfg_th_low = '0; cnt_clr = 1'b0;

        // Reset state (outputs also checked against model inside each cycle)
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_th_high", int'($signed(th_high)), 64);
        checkOutput("rst_th_low", int'($signed(th_low)), 0);
        checkOutput("rst_count", int'(spk_count), 0);
        checkOutput("rst_err", int'(cfg_err), 0);

        // Armed fire threshold
        applyStimulus(0, 63, 1, 0, 0, 0, 0, 0);
        checkOutput("armed63", lastSpk, 0);
        applyStimulus(0, 64, 1, 0, 0, 0, 0, 0);
        checkOutput("armed64", lastSpk, 1);
        applyStimulus(0, 127, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, -128, 1, 0, 0, 0, 0, 0);

        // Refractory hysteresis
        applyStimulus(0, 127, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("refr0_sb", lastSbOut, 0);
        applyStimulus(0, -1, 0, 0, 0, 0, 0, 0);
        checkOutput("refrm1_sb", lastSbOut, 1);

        // Full spike cycle with spikability fed back from the DUT
        fbPot    = '{100, 100, 10, -5, 100};
        fbSpkExp = '{1, 0, 0, 0, 1};
        fbSbExp  = '{0, 0, 0, 1, 0};
        sb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, fbPot[i], sb, 0, 0, 0, 0, 0);
            checkOutput($sformatf("fb_spk%0d", i), lastSpk, fbSpkExp[i]);
            checkOutput($sformatf("fb_sb%0d", i), lastSbOut, fbSbExp[i]);
            sb = lastSbOut[0];
        end

        // Threshold programming: valid write, then an equal pair is rejected
        applyStimulus(0, 0, 0, 0, 1, 20, -10, 0);
        applyStimulus(0, 20, 1, 0, 0, 0, 0, 0);
        checkOutput("prog_th_high", int'($signed(th_high)), 20);
        checkOutput("prog_th_low", int'($signed(th_low)), -10);
        checkOutput("prog_fire20", lastSpk, 1);
        applyStimulus(0, 0, 0, 0, 1, 5, 5, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rej_th_high", int'($signed(th_high)), 20);
        checkOutput("rej_err", int'(cfg_err), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rej_err_sticky", int'(cfg_err), 1);

        // Counter: three counted spikes, an uncounted spike, clear vs spike
        for (int i = 0; i < 3; i++) applyStimulus(0, 100, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 100, 1, 0, 0, 0, 0, 0);
        checkOutput("cnt3", int'(spk_count), 3);
        applyStimulus(0, 100, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("cnt_clr", int'(spk_count), 0);

        // Saturation: fill to all ones, then one more spike must not wrap
        for (int i = 0; i < 65535; i++) applyStimulus(0, 100, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 100, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("cnt_sat", int'(spk_count), 65535);

        // Reset mid-operation with a write and a counted spike pending
        applyStimulus(1, 100, 1, 1, 1, 30, -30, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_th_high", int'($signed(th_high)), 64);
        checkOutput("mid_th_low", int'($signed(th_low)), 0);
        checkOutput("mid_count", int'(spk_count), 0);
        checkOutput("mid_err", int'(cfg_err), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            applyStimulus(r == 0,
                          int'($urandom_range(0, 255)) - 128,
                          1'($urandom),
                          1'($urandom),
                          r >= 1 && r < 8,
                          int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)) - 128,
                          r >= 8 && r < 11);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spk_schmitt_trigger.md
Name: spk_schmitt_trigger

Overview:
- Per-neuron spike generator with hysteresis for the SNN accelerator's spike processor.
- Compares one neuron's signed 8-bit membrane potential against high and low thresholds, gated by the neuron's stored spikability bit.
- Produces the spike and the next spikability combinationally, so it can sit inside the 16-lane hidden/output layer arrays.
- Owns a pair of programmable threshold registers and a saturating spike counter, both clocked.

Parameters:
- WIDTH, 8, bit width of potential and thresholds (two's-complement signed).
- TH_HIGH_RST, 8'sd64, reset value of the high (fire) threshold.
- TH_LOW_RST, 8'sd0, reset value of the low (re-arm) threshold.
- CNT_WIDTH, 16, width of the spike counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- potential  in  WIDTH  signed membrane potential of the neuron.
- spkblty_in  in  1  stored spikability: 1 = armed, 0 = refractory.
- spk  out  1  spike output, combinational.
- spkblty_out  out  1  next spikability, combinational; written back by the caller.
- count_en  in  1  qualifies the current potential/spkblty_in as a real evaluation for counting.
- cfg_we  in  1  threshold write strobe.
- cfg_th_high  in  WIDTH  new high threshold, signed.
- cfg_th_low  in  WIDTH  new low threshold, signed.
- cfg_err  out  1  sticky flag: a rejected threshold write occurred.
- cnt_clr  in  1  clear spike counter.
- spk_count  out  CNT_WIDTH  number of counted spikes, saturating.
- th_high  out  WIDTH  current high threshold register.
- th_low  out  WIDTH  current low threshold register.

Behaviour:
- All comparisons are signed two's-complement on WIDTH bits.
- Core logic is purely combinational, with zero latency from potential, spkblty_in and the threshold registers:
  - spkblty_in=1 and potential >= th_high: spk=1, spkblty_out=0 (fire, then go refractory).
  - spkblty_in=1 and potential < th_high: spk=0, spkblty_out=1.
  - spkblty_in=0 and potential < th_low: spk=0, spkblty_out=1 (re-arm).
  - spkblty_in=0 and potential >= th_low: spk=0, spkblty_out=0.
- spk is never 1 while spkblty_in=0.
- Equality at th_high fires. Equality at th_low does not re-arm.
- Core outputs do not depend on reset; they remain valid combinational functions during reset, using the reset threshold values.
- Threshold registers:
  - On reset: th_high=TH_HIGH_RST, th_low=TH_LOW_RST, cfg_err=0.
  - On a clock edge with cfg_we=1 and cfg_th_low < cfg_th_high (signed): both registers load.
  - Otherwise, when cfg_we=1: the write is ignored and cfg_err is set to 1.
  - cfg_err stays at 1 until reset.
  - New thresholds affect spk/spkblty_out starting the cycle after the write edge.
- Spike counter:
  - On reset: spk_count=0.
  - Per clock edge, in priority order:
    1. cnt_clr=1: spk_count <= 0. cnt_clr wins over a simultaneous spike.
    2. count_en=1, spk=1 and spk_count < all-ones: spk_count increments by 1.
    3. At all-ones: holds (saturates, no wrap).
  - The counter samples the combinational spk of the same cycle.
- Reset asserted mid-operation takes effect at the next edge, regardless of cfg_we, cnt_clr or count_en.
- No X propagation: every register has a defined reset value.

Test Plan:
- Armed fire threshold (reset thresholds 64/0), spkblty_in=1:
  - potential=63 -> spk=0, spkblty_out=1.
  - potential=64 -> spk=1, spkblty_out=0.
  - potential=127 -> spk=1, spkblty_out=0.
  - potential=-128 -> spk=0, spkblty_out=1.
- Refractory hysteresis, spkblty_in=0:
  - potential=127 -> spk=0, spkblty_out=0.
  - potential=0 -> spk=0, spkblty_out=0.
  - potential=-1 -> spk=0, spkblty_out=1.
- Full spike cycle via feedback register: apply potential 100, 100, 10, -5, 100 with spkblty fed back each cycle.
  - Required spk sequence: 1, 0, 0, 0, 1.
  - Required spkblty sequence: 0, 0, 0, 1, 0.
- Threshold programming:
  - cfg_we with high=20, low=-10 -> th_high=20, th_low=-10 next cycle; potential=20 armed then fires.
  - cfg_we with high=5, low=5 -> ignored, thresholds stay 20/-10, cfg_err=1 until reset.
- Counter:
  - 3 cycles of count_en=1 with spk=1 -> spk_count=3.
  - spk=1 with count_en=0 -> no change.
  - cnt_clr together with a spike -> 0.
  - Preloaded to 16'hFFFF (via 65535 spikes) plus another spike -> stays 16'hFFFF.
- Reset mid-operation:
  - Assert reset while cfg_we=1 and a spike is counted -> next cycle th_high=64, th_low=0, spk_count=0, cfg_err=0.
